// File: rtl/fma_mant_adder.sv
// ---------------------------------------------------------------------------
// fma_mant_adder
//
// Two-stage pipelined mantissa adder for the FMA datapath. It sits between
// the pre-normalizer and the post-normalizer.
//   Stage 1: 3:2 compression of the aligned addend (sign-extended to 76 bits)
//            and the multiplier's carry-save product (sum/carry vectors).
//   Stage 2: 76-bit carry-propagate add, two's-complement to sign-magnitude
//            conversion, sign fix-up and leading-zero count.
// A valid/ready handshake gives full backpressure at one result per cycle.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   flush_i                 synchronous kill of both pipeline stages
//   valid_i / ready_o       upstream handshake (ready_o depends on ready_i)
//   A_Mant_aligned_i        aligned addend, bit 74 = subtract marker
//   Wallace_sum_i/_carry_i  carry-save product vectors
//   Exp_aligned_i, Sign_aligned_i, Sub_Sign_i, Mant_sticky_i, Mv_halt_i
//                           sideband from the pre-normalizer
//   valid_o / ready_i       downstream handshake
//   Mant_o, Lzc_o           sum magnitude and its leading-zero count
//   Exp_o, Sign_o, Sign_change_o, Sticky_o, Mv_halt_o
//                           result sideband
// ---------------------------------------------------------------------------
module fma_mant_adder #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [74:0]              A_Mant_aligned_i,
    input  logic [2*PARM_MANT+1:0]   Wallace_sum_i,
    input  logic [2*PARM_MANT+1:0]   Wallace_carry_i,
    input  logic [PARM_EXP+1:0]      Exp_aligned_i,
    input  logic                     Sign_aligned_i,
    input  logic                     Sub_Sign_i,
    input  logic                     Mant_sticky_i,
    input  logic                     Mv_halt_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [74:0]              Mant_o,
    output logic [6:0]               Lzc_o,
    output logic [PARM_EXP+1:0]      Exp_o,
    output logic                     Sign_o,
    output logic                     Sign_change_o,
    output logic                     Sticky_o,
    output logic                     Mv_halt_o
);

    // Leading zeros of a 75-bit value counted from bit 74; 75 for zero.
    function automatic logic [6:0] lzc75(input logic [74:0] v);
        lzc75 = 7'd75;
        for (int i = 0; i < 75; i++) begin
            if (v[i]) lzc75 = 7'(74 - i);
        end
    endfunction

    // ---------------- pipeline control ----------------
    logic v1_q, v1_d;
    logic valid_q, valid_d;
    logic s2_hold;
    logic accept;
    logic s2_load;

    assign s2_hold = valid_q & ~ready_i;
    // Stage 1 may load whenever it is empty or stage 2 is moving; no skid buffer.
    assign ready_o = ~v1_q | ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;
    assign s2_load = v1_q & ~s2_hold;

    always_comb begin
        // NOTE: defaults first so every path assigns the next state and no latch is inferred.
        v1_d    = v1_q;
        valid_d = valid_q;
        if (flush_i) begin
            v1_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (ready_o) v1_d = valid_i;
            if (!s2_hold) valid_d = v1_q;
        end
    end

    // ---------------- stage 1: 3:2 compression ----------------
    logic [75:0] op_x, op_y, op_z;
    logic [75:0] s1_d, c1_d;
    logic        cin;

    assign op_x = {A_Mant_aligned_i[74], A_Mant_aligned_i};
    assign op_y = 76'(Wallace_sum_i);
    assign op_z = 76'(Wallace_carry_i);
    // With sticky set, the shifted-out bits absorb the +1 of the negation.
    assign cin  = Sub_Sign_i & ~Mant_sticky_i;

    always_comb begin
        logic [75:0] maj;
        maj  = (op_x & op_y) | (op_x & op_z) | (op_y & op_z);
        s1_d = op_x ^ op_y ^ op_z;
        c1_d = {maj[74:0], cin};
    end

    logic [75:0]           s1_q, c1_q;
    logic [PARM_EXP+1:0]   exp1_q;
    logic                  sign1_q, sub1_q, sticky1_q, halt1_q;

    // NOTE: data registers are reset too, so every output reads 0 during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= '0;
            c1_q      <= '0;
            exp1_q    <= '0;
            sign1_q   <= 1'b0;
            sub1_q    <= 1'b0;
            sticky1_q <= 1'b0;
            halt1_q   <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so all stage registers update from pre-edge values.
            s1_q      <= s1_d;
            c1_q      <= c1_d;
            exp1_q    <= Exp_aligned_i;
            sign1_q   <= Sign_aligned_i;
            sub1_q    <= Sub_Sign_i;
            sticky1_q <= Mant_sticky_i;
            halt1_q   <= Mv_halt_i;
        end
    end

    // ---------------- stage 2: CPA, magnitude, LZC ----------------
    logic [75:0] sum_r;
    logic        neg;
    logic [74:0] mant_d;
    logic [6:0]  lzc_d;
    logic        sign_d;

    always_comb begin
        sum_r  = s1_q + c1_q;
        neg    = sum_r[75];
        // Low 75 bits of the 76-bit negation equal the 75-bit negation.
        mant_d = neg ? (~sum_r[74:0] + 75'd1) : sum_r[74:0];
        lzc_d  = lzc75(mant_d);
        // Exact cancellation of an effective subtraction yields +0.
        if ((sum_r == 76'd0) && sub1_q) sign_d = 1'b0;
        else                            sign_d = sign1_q ^ neg;
    end

    logic [74:0]           mant_q;
    logic [6:0]            lzc_q;
    logic [PARM_EXP+1:0]   exp2_q;
    logic                  sign2_q, chg2_q, sticky2_q, halt2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mant_q    <= '0;
            lzc_q     <= '0;
            exp2_q    <= '0;
            sign2_q   <= 1'b0;
            chg2_q    <= 1'b0;
            sticky2_q <= 1'b0;
            halt2_q   <= 1'b0;
        end else if (s2_load) begin
            mant_q    <= mant_d;
            lzc_q     <= lzc_d;
            exp2_q    <= exp1_q;
            sign2_q   <= sign_d;
            chg2_q    <= neg;
            sticky2_q <= sticky1_q;
            halt2_q   <= halt1_q;
        end
    end

    assign valid_o       = valid_q;
    assign Mant_o        = mant_q;
    assign Lzc_o         = lzc_q;
    assign Exp_o         = exp2_q;
    assign Sign_o        = sign2_q;
    assign Sign_change_o = chg2_q;
    assign Sticky_o      = sticky2_q;
    assign Mv_halt_o     = halt2_q;

endmodule

// File: tb/tb_fma_mant_adder.sv
// ---------------------------------------------------------------------------
// tb_fma_mant_adder
//
// Self-checking bench for fma_mant_adder. A queue-based reference model
// computes each result with plain 76-bit arithmetic; one negedge process
// compares every valid output against the oldest outstanding operation.
// Directed cases pin the model with hand-computed literals, then backpressure,
// flush, randomized traffic and a mid-stream reset are exercised.
// ---------------------------------------------------------------------------
module tb_fma_mant_adder;

    typedef struct packed {
        logic [74:0] a;
        logic [47:0] sum;
        logic [47:0] carry;
        logic [9:0]  exp;
        logic        sign;
        logic        sub;
        logic        sticky;
        logic        halt;
    } op_t;

    // {mant, lzc, exp, sign, sign_change, sticky, halt}
    typedef logic [95:0] res_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [74:0] a_i = '0;
    logic [47:0] sum_i = '0;
    logic [47:0] carry_i = '0;
    logic [9:0]  exp_i = '0;
    logic        sign_i = 1'b0;
    logic        sub_i = 1'b0;
    logic        sticky_i = 1'b0;
    logic        halt_i = 1'b0;

    logic        ready_o, valid_o;
    logic [74:0] Mant_o;
    logic [6:0]  Lzc_o;
    logic [9:0]  Exp_o;
    logic        Sign_o, Sign_change_o, Sticky_o, Mv_halt_o;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    int wait_cnt = 0;
    op_t q[$];

    fma_mant_adder #(.PARM_EXP(8), .PARM_MANT(23)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .A_Mant_aligned_i(a_i),
        .Wallace_sum_i   (sum_i),
        .Wallace_carry_i (carry_i),
        .Exp_aligned_i   (exp_i),
        .Sign_aligned_i  (sign_i),
        .Sub_Sign_i      (sub_i),
        .Mant_sticky_i   (sticky_i),
        .Mv_halt_i       (halt_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .Mant_o          (Mant_o),
        .Lzc_o           (Lzc_o),
        .Exp_o           (Exp_o),
        .Sign_o          (Sign_o),
        .Sign_change_o   (Sign_change_o),
        .Sticky_o        (Sticky_o),
        .Mv_halt_o       (Mv_halt_o)
    );

    always #5 clk_i = ~clk_i;

    op_t  in_op;
    res_t act;
    assign in_op = {a_i, sum_i, carry_i, exp_i, sign_i, sub_i, sticky_i, halt_i};
    assign act   = {Mant_o, Lzc_o, Exp_o, Sign_o, Sign_change_o, Sticky_o, Mv_halt_o};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, req, $time);
        end
    endtask

    // Reference: sign-extended addend plus both product vectors plus carry-in.
    function automatic res_t model(input op_t op);
        logic [75:0] r, nr;
        logic [74:0] m;
        logic        s;
        int          n;
        r  = {op.a[74], op.a} + {28'd0, op.sum} + {28'd0, op.carry}
           + 76'(op.sub & ~op.sticky);
        nr = 76'd0 - r;
        m  = r[75] ? nr[74:0] : r[74:0];
        n  = 0;
        for (int k = 74; k >= 0; k--) begin
            if (m[k]) break;
            n++;
        end
        s = (r == 76'd0 && op.sub) ? 1'b0 : (op.sign ^ r[75]);
        return {m, 7'(n), op.exp, s, r[75], op.sticky, op.halt};
    endfunction

    function automatic op_t rand_op();
        op_t         op;
        logic [95:0] ra;
        logic [63:0] rs, rc;
        logic [75:0] tot, na;
        ra = {$urandom(), $urandom(), $urandom()};
        rs = {$urandom(), $urandom()};
        rc = {$urandom(), $urandom()};
        op.a      = ra[74:0];
        op.sum    = rs[47:0];
        op.carry  = rc[47:0];
        op.exp    = 10'($urandom());
        op.sign   = 1'($urandom());
        op.sub    = 1'($urandom());
        op.sticky = ($urandom() % 4) == 0;
        op.halt   = 1'($urandom());
        if ($urandom() % 4 == 0) op.a = {27'd0, rs[47:0]} << ($urandom() % 27);
        if (op.sub) op.a[74] = 1'b1;
        if ($urandom() % 8 == 0) begin
            // Exact cancellation against the product.
            op.sub    = 1'b1;
            op.sticky = 1'b0;
            tot  = {28'd0, op.sum} + {28'd0, op.carry} + 76'd1;
            na   = 76'd0 - tot;
            op.a = na[74:0];
        end
        return op;
    endfunction

    // Compare process: sample mid-cycle, then advance the model for the next edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
            wait_cnt = 0;
            check("reset_outputs", {valid_o, act}, '0);
        end else begin
            check("ready_o", ready_o, (q.size() < 2) || ready_i);
            if (valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got valid_o=1 required 0 (t=%0t)", $time);
                end else begin
                    check("result", act, model(q[0]));
                end
            end
            if (q.size() > 0 && !valid_o) wait_cnt++;
            else                         wait_cnt = 0;
            if (wait_cnt > 1) begin
                checks++;
                errors++;
                $display("FAIL latency: got %0d idle cycles required at most 1 (t=%0t)", wait_cnt, $time);
                wait_cnt = 0;
            end
            if (flush_i) q.delete();
            else begin
                if (valid_o && ready_i) begin
                    void'(q.pop_front());
                    out_cnt++;
                end
                if (valid_i && ready_o) q.push_back(in_op);
            end
        end
    end

    task automatic drive(input op_t op);
        a_i      = op.a;
        sum_i    = op.sum;
        carry_i  = op.carry;
        exp_i    = op.exp;
        sign_i   = op.sign;
        sub_i    = op.sub;
        sticky_i = op.sticky;
        halt_i   = op.halt;
    endtask

    // Present one op and hold it until accepted; returns cycles spent stalled.
    task automatic send(input op_t op, output int waits);
        drive(op);
        valid_i = 1'b1;
        waits = 0;
        @(negedge clk_i);
        while (!ready_o && waits < 50) begin
            waits++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready_o=0 for %0d cycles required 1", waits);
        end
        @(posedge clk_i);
        #2;
        valid_i = 1'b0;
    endtask

    task automatic run_literal(input string tag, input op_t op, input logic [74:0] m,
                               input logic [6:0] l, input logic s, input logic chg);
        int w, cnt;
        send(op, w);
        cnt = 1;
        @(negedge clk_i);
        while (!valid_o && cnt < 8) begin
            cnt++;
            @(negedge clk_i);
        end
        check({tag, "_latency"}, cnt, 2);
        check({tag, "_mant"}, Mant_o, m);
        check({tag, "_lzc"}, Lzc_o, l);
        check({tag, "_sign"}, Sign_o, s);
        check({tag, "_chg"}, Sign_change_o, chg);
        check({tag, "_side"}, {Exp_o, Sticky_o, Mv_halt_o}, {op.exp, op.sticky, op.halt});
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t         o;
        int          w[4];
        int          wd;
        int          base;
        logic [73:0] t;

        // Power-on reset.
        repeat (2) @(posedge clk_i);
        #1;
        check("por_outputs", {valid_o, act}, '0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        #1;
        check("por_ready", ready_o, 1'b1);
        @(posedge clk_i);
        #2;

        // Add, no sign change.
        o = '0;
        o.a = 75'd1 << 50; o.sum = 48'h3; o.sign = 1'b1; o.exp = 10'h155; o.halt = 1'b1;
        run_literal("add", o, (75'd1 << 50) + 75'd3, 7'd24, 1'b1, 1'b0);

        // Subtract with sign change: -9 + 3 + 1 = -5.
        o = '0;
        t = 74'd8;
        o.a = {1'b1, ~t}; o.sum = 48'd3; o.sub = 1'b1; o.exp = 10'h2aa; o.sticky = 1'b0;
        run_literal("sub", o, 75'd5, 7'd72, 1'b1, 1'b1);

        // Exact cancellation: -4 + 1 + 2 + 1 = 0 gives +0.
        o = '0;
        t = 74'd3;
        o.a = {1'b1, ~t}; o.sum = 48'd1; o.carry = 48'd2; o.sub = 1'b1; o.sign = 1'b1;
        run_literal("cancel", o, 75'd0, 7'd75, 1'b0, 1'b0);

        // Backpressure: 4 ops, ready_i low for 3 cycles once the first result is valid.
        base = out_cnt;
        ready_i = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    op_t bo;
                    bo = rand_op();
                    send(bo, w[i]);
                end
            end
            begin
                int k;
                k = 0;
                while (!valid_o && k < 20) begin
                    @(posedge clk_i);
                    #2;
                    k++;
                end
                ready_i = 1'b0;
                repeat (3) begin
                    @(posedge clk_i);
                    #2;
                end
                ready_i = 1'b1;
            end
        join
        check("bp_op1_wait", w[1], 0);
        check("bp_op2_wait", w[2], 3);
        repeat (6) begin
            @(posedge clk_i);
            #2;
        end
        check("bp_count", out_cnt - base, 4);

        // Flush with both stages full and a simultaneous accept.
        base = out_cnt;
        ready_i = 1'b0;
        o = rand_op(); send(o, wd);
        o = rand_op(); send(o, wd);
        check("flush_full_ready", ready_o, 1'b0);
        o = rand_op(); drive(o);
        valid_i = 1'b1;
        ready_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("flush_valid", valid_o, 1'b0);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check("flush_no_stale", valid_o, 1'b0);
            #1;
        end
        check("flush_count", out_cnt - base, 0);

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 800; i++) begin
            drive(rand_op());
            valid_i = ($urandom() % 10) < 7;
            ready_i = ($urandom() % 10) < 7;
            flush_i = ($urandom() % 32) == 0;
            @(posedge clk_i);
            #2;
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) begin
            @(posedge clk_i);
            #2;
        end
        check("random_drain", q.size(), 0);

        // Mid-stream asynchronous reset.
        ready_i = 1'b0;
        o = rand_op(); send(o, wd);
        o = rand_op(); send(o, wd);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rst_async_outputs", {valid_o, act}, '0);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        #1;
        check("rst_release_ready", ready_o, 1'b1);
        @(posedge clk_i);
        #2;
        ready_i = 1'b1;
        base = out_cnt;
        for (int i = 0; i < 5; i++) begin
            o = rand_op();
            send(o, wd);
        end
        repeat (6) begin
            @(posedge clk_i);
            #2;
        end
        check("post_reset_count", out_cnt - base, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
